// File: rtl/dmem_responder.sv
// dmem_responder: behavioural word-addressed data memory for the load/store path.
// Accepts one read or write at a time. Each request completes after LATENCY cycles
// with a one-cycle done pulse, followed by one mandatory IDLE cycle.
module dmem_responder #(
  parameter int DEPTH_POW2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        dmem_read_i,
  input  logic        dmem_write_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_rd_data_o,
  output logic        dmem_done_o,
  output logic        busy_o,
  output logic        conflict_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [DEPTH_POW2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    wr_q;
  logic [DEPTH_POW2-1:0]   addr_idx;
  logic [31:0]             mem [0:(1<<DEPTH_POW2)-1];

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign addr_idx = dmem_addr_i[DEPTH_POW2+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmem_addr_i[1:0], dmem_addr_i[31:DEPTH_POW2+2]};

  assign busy_o = (state != IDLE);

  // Request sequencer: latch the request, count down the latency, pulse done.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      dmem_done_o    <= 1'b0;
      dmem_rd_data_o <= 32'd0;
      conflict_o     <= 1'b0;
    end else begin
      dmem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem_read_i | dmem_write_i) begin
            // Write wins over a simultaneous read; the read is dropped.
            idx_q   <= addr_idx;
            wdata_q <= dmem_data_i;
            wr_q    <= dmem_write_i;
            cnt     <= 4'(LATENCY - 1);
            if (dmem_read_i & dmem_write_i)
              conflict_o <= 1'b1;
            if (LATENCY == 1) begin
              state       <= DONE;
              dmem_done_o <= 1'b1;
              if (!dmem_write_i)
                dmem_rd_data_o <= mem[addr_idx];
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // Inputs ignored here; the latched request is authoritative.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= DONE;
            dmem_done_o <= 1'b1;
            if (!wr_q)
              dmem_rd_data_o <= mem[idx_q];
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array write commits on the edge leaving DONE; a reset there discards it.
  always_ff @(posedge clk_i) begin
    if (!reset_i && state == DONE && wr_q)
      mem[idx_q] <= wdata_q;
  end

endmodule
